// File: rtl/blt_outer_pkg.sv
// Shared types for the blitter outer-loop sequencer.
package blt_outer_pkg;

  // One-hot state encoding; each bit doubles as the registered output strobe.
  typedef enum logic [8:0] {
    S_IDLE   = 9'b0_0000_0001,
    S_RDCMD  = 9'b0_0000_0010,
    S_RDPAR  = 9'b0_0000_0100,
    S_LDCNT  = 9'b0_0000_1000,
    S_INNER  = 9'b0_0001_0000,
    S_UPDSRC = 9'b0_0010_0000,
    S_UPDDST = 9'b0_0100_0000,
    S_CHKOUT = 9'b0_1000_0000,
    S_FIN    = 9'b1_0000_0000
  } state_e;

  localparam int unsigned ST_IDLE   = 0;
  localparam int unsigned ST_RDCMD  = 1;
  localparam int unsigned ST_RDPAR  = 2;
  localparam int unsigned ST_LDCNT  = 3;
  localparam int unsigned ST_INNER  = 4;
  localparam int unsigned ST_UPDSRC = 5;
  localparam int unsigned ST_UPDDST = 6;
  localparam int unsigned ST_FIN    = 8;

  typedef struct packed {
    logic parrd;
    logic srcup;
    logic dstup;
    logic link;
  } flags_t;

  // First state of a new outer pass.
  function automatic state_e pass_start(input flags_t f);
    return f.parrd ? S_RDPAR : S_LDCNT;
  endfunction

  // State following the end of the inner loop.
  function automatic state_e post_inner(input flags_t f);
    if (f.srcup)      return S_UPDSRC;
    else if (f.dstup) return S_UPDDST;
    else              return S_CHKOUT;
  endfunction

endpackage

// File: rtl/blt_outer_cnt.sv
// Outer pass down counter: load, non-wrapping decrement, synchronous clear.
module blt_outer_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load beats decrement; zero is never decremented.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (ld_i)
      cnt_d = ld_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/blt_outer_seq.sv
// Blitter outer-loop sequencer: command/parameter read, inner-loop launch,
// address update strobes and outer pass counting with chaining, abort and
// single-step.
module blt_outer_seq
  import blt_outer_pkg::*;
#(
  parameter int unsigned OCNT_W  = 8,
  parameter bit          STEP_EN = 1'b1
) (
  input  logic              CCLK,
  input  logic              SRESET,
  input  logic              START,
  input  logic              STOP,
  input  logic              COMDN,
  input  logic              CMD_PARRD,
  input  logic              CMD_SRCUP,
  input  logic              CMD_DSTUP,
  input  logic              CMD_LINK,
  input  logic [OCNT_W-1:0] OCNT_INIT,
  input  logic              PARDN,
  input  logic              IQUIET,
  input  logic              STEPMODE,
  input  logic              STEP,
  output logic              RDCMD,
  output logic              RDPAR,
  output logic              LDICNT,
  output logic              INLP,
  output logic              UPDSRC,
  output logic              UPDDST,
  output logic              OTCLK,
  output logic [OCNT_W-1:0] OCNT,
  output logic              BUSY,
  output logic              DONE
);

  state_e state_q, state_d;
  flags_t flags_q, flags_d;
  flags_t cmd_flags;
  logic   otclk_q, otclk_d;
  logic   cnt_ld, cnt_dec, cnt_clr, cnt_zero;
  logic   step_hold;

  assign cmd_flags = '{parrd: CMD_PARRD, srcup: CMD_SRCUP,
                       dstup: CMD_DSTUP, link: CMD_LINK};
  assign step_hold = STEP_EN && STEPMODE && !STEP;
  assign cnt_clr   = SRESET || STOP;

  blt_outer_cnt #(.W(OCNT_W)) u_cnt (
    .clk_i    (CCLK),
    .clr_i    (cnt_clr),
    .ld_i     (cnt_ld),
    .ld_val_i (OCNT_INIT),
    .dec_i    (cnt_dec),
    .cnt_o    (OCNT),
    .zero_o   (cnt_zero)
  );

  // Next-state, flag latch and counter control; STOP overrides every state.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    otclk_d = 1'b0;
    if (STOP) begin
      state_d = S_IDLE;
      flags_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE:   if (START) state_d = S_RDCMD;
        S_RDCMD:  if (COMDN) begin
                    flags_d = cmd_flags;
                    cnt_ld  = 1'b1;
                    state_d = (OCNT_INIT == '0) ? S_FIN : pass_start(cmd_flags);
                  end
        S_RDPAR:  if (PARDN) state_d = S_LDCNT;
        S_LDCNT:  state_d = S_INNER;
        S_INNER:  if (IQUIET) begin
                    cnt_dec = 1'b1;
                    otclk_d = 1'b1;
                    state_d = post_inner(flags_q);
                  end
        S_UPDSRC: state_d = flags_q.dstup ? S_UPDDST : S_CHKOUT;
        S_UPDDST: state_d = S_CHKOUT;
        S_CHKOUT: if (cnt_zero)        state_d = S_FIN;
                  else if (!step_hold) state_d = pass_start(flags_q);
        S_FIN:    state_d = flags_q.link ? S_RDCMD : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State, latched flags and pass-complete pulse registers.
  always_ff @(posedge CCLK) begin
    if (SRESET) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      otclk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      otclk_q <= otclk_d;
    end
  end

  // Strobes are taken straight from the one-hot state register bits.
  assign RDCMD  = state_q[ST_RDCMD];
  assign RDPAR  = state_q[ST_RDPAR];
  assign LDICNT = state_q[ST_LDCNT];
  assign INLP   = state_q[ST_INNER];
  assign UPDSRC = state_q[ST_UPDSRC];
  assign UPDDST = state_q[ST_UPDDST];
  assign DONE   = state_q[ST_FIN];
  assign BUSY   = ~state_q[ST_IDLE];
  assign OTCLK  = otclk_q;

endmodule

// File: tb/tb_blt_outer_seq.sv
// Scoreboard bench for blt_outer_seq: stimulus queues expected OTCLK/DONE
// events, a negedge monitor pops and compares them and records a strobe trace.
module tb_blt_outer_seq;

  logic       CCLK, SRESET, START, STOP, COMDN;
  logic       CMD_PARRD, CMD_SRCUP, CMD_DSTUP, CMD_LINK;
  logic [7:0] OCNT_INIT;
  logic       PARDN, IQUIET, STEPMODE, STEP;
  logic       RDCMD, RDPAR, LDICNT, INLP, UPDSRC, UPDDST, OTCLK, BUSY, DONE;
  logic [7:0] OCNT;

  blt_outer_seq #(.OCNT_W(8), .STEP_EN(1'b1)) dut (
    .CCLK(CCLK), .SRESET(SRESET), .START(START), .STOP(STOP), .COMDN(COMDN),
    .CMD_PARRD(CMD_PARRD), .CMD_SRCUP(CMD_SRCUP), .CMD_DSTUP(CMD_DSTUP),
    .CMD_LINK(CMD_LINK), .OCNT_INIT(OCNT_INIT), .PARDN(PARDN), .IQUIET(IQUIET),
    .STEPMODE(STEPMODE), .STEP(STEP), .RDCMD(RDCMD), .RDPAR(RDPAR),
    .LDICNT(LDICNT), .INLP(INLP), .UPDSRC(UPDSRC), .UPDDST(UPDDST),
    .OTCLK(OTCLK), .OCNT(OCNT), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    bit parrd, srcup, dstup, link;
    int n;
  } cmd_t;

  cmd_t cmdq[$];
  int   evq[$];
  int   trace[$];
  int   total = 0;
  int   bad = 0;
  int   onehot_bad = 0;
  int   cmd_lat = 1, pd_lat = 1, iq_lat = 1;
  bit   iq_auto = 1;

  initial begin
    CCLK = 0;
    forever #5 CCLK = ~CCLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  // Responders for the fetch handshakes and the inner loop.
  initial begin
    int rc = 0, pc = 0, ic = 0;
    cmd_t c;
    COMDN = 0; PARDN = 0; IQUIET = 0;
    CMD_PARRD = 0; CMD_SRCUP = 0; CMD_DSTUP = 0; CMD_LINK = 0; OCNT_INIT = 0;
    forever begin
      @(posedge CCLK);
      #1;
      rc = RDCMD ? rc + 1 : 0;
      pc = RDPAR ? pc + 1 : 0;
      ic = INLP  ? ic + 1 : 0;
      COMDN = 0;
      if (RDCMD && rc >= cmd_lat && cmdq.size() > 0) begin
        c = cmdq.pop_front();
        CMD_PARRD = c.parrd; CMD_SRCUP = c.srcup;
        CMD_DSTUP = c.dstup; CMD_LINK  = c.link;
        OCNT_INIT = 8'(c.n);
        COMDN = 1;
      end
      PARDN = RDPAR && (pc >= pd_lat);
      if (iq_auto) IQUIET = INLP && (ic >= iq_lat);
    end
  end

  function automatic int code();
    if (RDCMD)  return 1;
    if (RDPAR)  return 2;
    if (LDICNT) return 3;
    if (INLP)   return 4;
    if (UPDSRC) return 5;
    if (UPDDST) return 6;
    if (DONE)   return 7;
    return 0;
  endfunction

  task automatic check_evt(input int kind);
    int e;
    total++;
    if (evq.size() == 0) begin
      bad++;
      $display("FAIL event: got kind=%0d ocnt=%0d expected no event", kind, OCNT);
    end else begin
      e = evq.pop_front();
      if (e != ((kind << 16) | int'(OCNT))) begin
        bad++;
        $display("FAIL event: got kind=%0d ocnt=%0d expected kind=%0d ocnt=%0d",
                 kind, OCNT, e >> 16, e & 16'hffff);
      end
    end
  endtask

  // Monitor: scoreboard pops on OTCLK/DONE, trace capture, one-hot watch.
  always @(negedge CCLK) begin
    if (OTCLK) check_evt(0);
    if (DONE)  check_evt(1);
    if (BUSY)  trace.push_back(code());
    if ($countones({RDCMD, RDPAR, LDICNT, INLP, UPDSRC, UPDDST, DONE}) > 1)
      onehot_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_trace(input string name, input int e[$]);
    int idx = -1;
    total++;
    for (int i = 0; i < e.size() && i < trace.size(); i++)
      if (idx < 0 && trace[i] != e[i]) idx = i;
    if (idx < 0 && trace.size() != e.size()) idx = (trace.size() < e.size()) ? trace.size() : e.size();
    if (idx >= 0) begin
      bad++;
      $display("FAIL %s: trace len %0d differs at %0d (got %0d) expected len %0d (want %0d)",
               name, trace.size(), idx, (idx < trace.size()) ? trace[idx] : -1,
               e.size(), (idx < e.size()) ? e[idx] : -1);
    end
  endtask

  task automatic issue(input bit p, input bit s, input bit d, input bit l, input int n);
    cmd_t c;
    c.parrd = p; c.srcup = s; c.dstup = d; c.link = l; c.n = n;
    cmdq.push_back(c);
    for (int k = n - 1; k >= 0; k--) evq.push_back(k);
    evq.push_back(1 << 16);
  endtask

  task automatic start_cmd();
    START = 1;
    tick();
    START = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (BUSY && i < budget) begin
      tick();
      i++;
    end
    if (BUSY) begin
      total++; bad++;
      $display("FAIL %s: got busy after %0d cycles expected idle", name, budget);
    end
  endtask

  task automatic wait_for(input bit use_otclk, input string name, input int budget);
    int i = 0;
    while (!(use_otclk ? OTCLK : INLP) && i < budget) begin
      tick();
      i++;
    end
    if (!(use_otclk ? OTCLK : INLP)) begin
      total++; bad++;
      $display("FAIL %s: got no event in %0d cycles expected event", name, budget);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, RDCMD, RDPAR, LDICNT, INLP, UPDSRC, UPDDST, OTCLK, DONE, BUSY, OCNT};
  endfunction

  initial begin
    SRESET = 1; START = 0; STOP = 0; STEPMODE = 0; STEP = 0;
    repeat (3) tick();
    chk("reset_outs", outs(), 32'h0);
    SRESET = 0;
    tick();

    // Three plain passes, inner loop two cycles each.
    iq_lat = 2;
    trace.delete();
    issue(0, 0, 0, 0, 3);
    start_cmd();
    chk("start_latency", {31'd0, RDCMD}, 32'h1);
    wait_idle("plain3", 60);
    check_trace("plain3", '{1, 3,4,4,0, 3,4,4,0, 3,4,4,0, 7});
    iq_lat = 1;

    // Two passes with parameter re-read and both address updates.
    pd_lat = 4;
    trace.delete();
    issue(1, 1, 1, 0, 2);
    start_cmd();
    wait_idle("full2", 60);
    check_trace("full2", '{1, 2,2,2,2,3,4,5,6,0, 2,2,2,2,3,4,5,6,0, 7});
    pd_lat = 1;

    // Zero passes.
    trace.delete();
    issue(0, 0, 0, 0, 0);
    start_cmd();
    wait_idle("zero", 20);
    check_trace("zero", '{1, 7});

    // Source-only and destination-only updates.
    trace.delete();
    issue(0, 1, 0, 0, 1);
    start_cmd();
    wait_idle("srconly", 20);
    check_trace("srconly", '{1, 3,4,5,0, 7});
    trace.delete();
    issue(0, 0, 1, 0, 1);
    start_cmd();
    wait_idle("dstonly", 20);
    check_trace("dstonly", '{1, 3,4,6,0, 7});

    // Linked commands.
    trace.delete();
    issue(0, 0, 0, 1, 1);
    issue(0, 0, 0, 0, 2);
    start_cmd();
    wait_idle("link", 60);
    check_trace("link", '{1, 3,4,0, 7, 1, 3,4,0, 3,4,0, 7});

    // STOP coincident with IQUIET in the first of five passes.
    iq_auto = 0;
    cmdq.push_back('{parrd: 1, srcup: 1, dstup: 1, link: 1, n: 5});
    start_cmd();
    wait_for(0, "stop_inlp", 20);
    chk("stop_ocnt_before", {24'd0, OCNT}, 32'd5);
    IQUIET = 1; STOP = 1;
    tick();
    STOP = 0; IQUIET = 0; iq_auto = 1;
    chk("stop_outs", outs(), 32'h0);
    tick();
    STOP = 1; START = 1;
    tick();
    STOP = 0; START = 0;
    chk("stop_start_idle", outs(), 32'h0);
    trace.delete();
    issue(0, 0, 0, 0, 1);
    start_cmd();
    wait_idle("after_stop", 20);
    check_trace("after_stop", '{1, 3,4,0, 7});

    // Single-step hold in CHKOUT.
    STEPMODE = 1;
    issue(0, 0, 0, 0, 2);
    start_cmd();
    wait_for(1, "step_pass1", 20);
    repeat (3) tick();
    chk("step_hold", outs(), {23'd0, 9'b1, 8'd0} | 32'h101);
    STEP = 1;
    tick();
    STEP = 0;
    chk("step_ldicnt", {31'd0, LDICNT}, 32'h1);
    wait_idle("step_fin", 20);

    // Synchronous reset during the step hold.
    cmdq.push_back('{parrd: 0, srcup: 0, dstup: 0, link: 0, n: 2});
    evq.push_back(1);
    start_cmd();
    wait_for(1, "rst_pass1", 20);
    repeat (2) tick();
    SRESET = 1;
    tick();
    chk("rst_hold_outs", outs(), 32'h0);
    SRESET = 0; STEPMODE = 0;
    tick();

    // Maximum pass count.
    issue(0, 0, 0, 0, 255);
    start_cmd();
    wait_idle("max255", 1000);

    repeat (3) tick();
    chk("events_drained", evq.size(), 32'd0);
    chk("onehot", onehot_bad, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blt_outer_seq.md
Name: blt_outer_seq

Overview:
Next-generation blitter outer-loop sequencer. It sequences command read, parameter read, inner-count load, inner loop, and source/destination address update for a parametrised number of outer passes. It adds an integrated outer counter, latched command flags, command chaining, abort, and single-step. It sits between the command/parameter fetch logic and the inner-loop state machine.

Parameters:
OCNT_W, 8, width of outer pass counter (1..16)
STEP_EN, 1, 1 = single-step logic present; 0 = STEPMODE/STEP ignored (tie-off)

Ports:
CCLK  in  1  system clock; all state changes on rising edge
SRESET  in  1  synchronous reset, active-high
START  in  1  begin a blit; sampled in IDLE only
STOP  in  1  synchronous abort
COMDN  in  1  command fetch complete; sampled in S_RDCMD only
CMD_PARRD  in  1  command flag: re-read parameters each outer pass; latched with COMDN
CMD_SRCUP  in  1  command flag: update source address per pass; latched with COMDN
CMD_DSTUP  in  1  command flag: update destination address per pass; latched with COMDN
CMD_LINK  in  1  command flag: chain to next command; latched with COMDN
OCNT_INIT  in  OCNT_W  outer pass count; latched with COMDN
PARDN  in  1  parameter fetch complete
IQUIET  in  1  inner loop finished
STEPMODE  in  1  hold before each new pass until STEP
STEP  in  1  single-step advance pulse
RDCMD  out  1  command read request
RDPAR  out  1  parameter read request
LDICNT  out  1  load inner counter (1-cycle pulse)
INLP  out  1  inner loop running
UPDSRC  out  1  source address update strobe (1 cycle)
UPDDST  out  1  destination address update strobe (1 cycle)
OTCLK  out  1  outer-pass-complete pulse (1 cycle)
OCNT  out  OCNT_W  remaining outer passes
BUSY  out  1  state != IDLE
DONE  out  1  command complete pulse (1 cycle)

Behaviour:
- States: IDLE, RDCMD, RDPAR, LDCNT, INNER, UPDSRC, UPDDST, CHKOUT, FIN.
- All outputs are registered Moore decodes of the state, except OTCLK and OCNT, which are registered.
- Reset: state IDLE. OCNT=0, latched flags=0, all outputs 0.
- IDLE: START -> RDCMD.
- RDCMD: RDCMD=1, held until COMDN.
  - On COMDN, latch CMD_* and load OCNT<=OCNT_INIT.
  - OCNT_INIT==0 -> FIN (zero passes, no LDICNT).
  - Otherwise, PARRD latched -> RDPAR; else -> LDCNT.
- RDPAR: RDPAR=1 until PARDN -> LDCNT.
- LDCNT: LDICNT=1 for exactly one cycle -> INNER.
- INNER: INLP=1 until IQUIET. On the IQUIET edge:
  - OCNT decrements by 1 (no wrap: 0 never decremented);
  - OTCLK=1 for the next single cycle;
  - next state is UPDSRC if SRCUP latched, else UPDDST if DSTUP latched, else CHKOUT.
- UPDSRC: 1 cycle -> UPDDST if DSTUP latched, else CHKOUT.
- UPDDST: 1 cycle -> CHKOUT.
- CHKOUT:
  - OCNT==0 -> FIN.
  - Else, if STEP_EN and STEPMODE and !STEP -> hold.
  - Else -> RDPAR if PARRD latched, else LDCNT.
- FIN: DONE=1 for one cycle. LINK latched -> RDCMD; else -> IDLE.
- Latency:
  - START to RDCMD = 1 cycle.
  - Minimum pass length (no PARRD/updates) = LDCNT + INNER(>=1) + CHKOUT = 3 cycles.
- STOP: from any state, next state IDLE. Same edge clears OCNT and latched flags. No DONE, no OTCLK.
  - STOP in INNER takes priority over a simultaneous IQUIET; no decrement.
  - STOP and START in the same cycle -> stays IDLE.
- SRESET overrides STOP and all other inputs.
- Ignored inputs: COMDN, PARDN, IQUIET and STEP outside their sampling states; START outside IDLE.
- At most one of RDCMD/RDPAR/LDICNT/INLP/UPDSRC/UPDDST/DONE is asserted in any cycle (one-hot outputs).
- OCNT_INIT = 2^OCNT_W-1 executes exactly 2^OCNT_W-1 passes.

Decomposition:
- Package blt_outer_pkg: state enum typedef (one-hot encoding, 9 bits) and a latched-flags struct {parrd, srcup, dstup, link}.
- One sub-module, blt_outer_cnt: OCNT_W-bit down counter with load, dec, clear and zero flag; synchronous, active-high clear.
- The sequencer module holds the FSM, the flag register and the output registers.

Test Plan:
- START, COMDN with OCNT_INIT=3, flags all 0, IQUIET 2 cycles after each INLP rise -> 3 LDICNT pulses, 3 OTCLK pulses, OCNT 3->2->1->0, one DONE, return to IDLE; no RDPAR/UPDSRC/UPDDST.
- OCNT_INIT=2, PARRD=SRCUP=DSTUP=1, PARDN after 4 cycles -> per pass the sequence RDPAR, LDICNT, INLP, UPDSRC then UPDDST on consecutive cycles; 2 passes, DONE once.
- OCNT_INIT=0 -> RDCMD, then FIN: DONE one cycle after COMDN; LDICNT never asserted; OCNT stays 0.
- LINK=1 on first command (OCNT_INIT=1), LINK=0 on second (OCNT_INIT=2) -> DONE, RDCMD next cycle, 3 OTCLK total, 2 DONE pulses, then IDLE.
- STOP asserted in INNER the same cycle as IQUIET, with OCNT=5 -> next cycle IDLE, OCNT=0, no OTCLK, no DONE, BUSY=0; subsequent START behaves as from reset.
- STEPMODE=1, OCNT_INIT=2 -> holds in CHKOUT after pass 1 (all strobes 0, BUSY=1) until STEP pulse, then LDICNT on the next cycle. SRESET mid-hold -> all outputs 0 next cycle.
